// File: rtl/circ_smpl_queue.sv
// circ_smpl_queue: decimating circular sample queue with windowed read-out bursts.
// Accepted samples go into an inferred dual-port RAM. Once WINDOW samples are
// held, each further accepted sample drops the oldest one and triggers a burst
// that reads the whole window, oldest first, one sample per clk.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   clr         - synchronous clear (same effect as reset)
//   new_smpl    - incoming sample, qualified by wrt_smpl
//   wrt_smpl    - one-clk write strobe
//   smpl_out    - burst read data, qualified by smpl_vld
//   smpl_vld    - smpl_out valid this cycle
//   sequencing  - burst in progress
//   full        - fill_cnt == WINDOW
//   overrun     - sticky: a burst request was lost
//   fill_cnt    - number of samples held
module circ_smpl_queue #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned WINDOW = 1021,
  parameter int unsigned DECIM  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             new_smpl,
  input  logic                         wrt_smpl,
  output logic [WIDTH-1:0]             smpl_out,
  output logic                         smpl_vld,
  output logic                         sequencing,
  output logic                         full,
  output logic                         overrun,
  output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t         state, state_n;
  logic [AW-1:0]  wr_ptr, wr_ptr_n;
  logic [AW-1:0]  old_ptr, old_ptr_n;
  logic [AW-1:0]  rd_ptr, rd_ptr_n;
  logic [CW-1:0]  rd_cnt, rd_cnt_n;
  logic [CW-1:0]  fill_n;
  logic [PW-1:0]  phase, phase_n;
  logic           pending, pend_n;
  logic           ovr_n;
  logic           vld_n;
  logic           full_n;

  logic           accept_c;
  logic           trig_c;
  logic           rd_en_c;
  logic           last_c;
  logic           we_c;

  logic [WIDTH-1:0] mem [DEPTH];

  // Next-state logic: decimation, pointer/fill bookkeeping and burst sequencing
  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    old_ptr_n = old_ptr;
    rd_ptr_n  = rd_ptr;
    rd_cnt_n  = rd_cnt;
    fill_n    = fill_cnt;
    phase_n   = phase;
    pend_n    = pending;
    ovr_n     = overrun;
    trig_c    = 1'b0;

    accept_c = wrt_smpl && (phase == PW'(DECIM - 1));
    // rd_cnt counts issued reads; the cycle after the last issue is the last valid
    rd_en_c  = (state == S_BURST) && (rd_cnt < CW'(WINDOW));
    last_c   = (state == S_BURST) && (rd_cnt == CW'(WINDOW));

    if (wrt_smpl) begin
      phase_n = accept_c ? '0 : phase + PW'(1);
    end

    if (accept_c) begin
      wr_ptr_n = wr_ptr + AW'(1);
      if (fill_cnt < CW'(WINDOW)) begin
        fill_n = fill_cnt + CW'(1);
      end else begin
        old_ptr_n = old_ptr + AW'(1);
      end
      trig_c = (fill_n == CW'(WINDOW));
    end

    if (rd_en_c) begin
      rd_ptr_n = rd_ptr + AW'(1);
      rd_cnt_n = rd_cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        if (trig_c) begin
          state_n  = S_BURST;
          rd_ptr_n = old_ptr_n;
          rd_cnt_n = '0;
        end
      end
      S_BURST: begin
        if (last_c) begin
          // Chain the next burst with no gap; a coincident trigger re-arms pending
          if (pending || trig_c) begin
            rd_ptr_n = old_ptr_n;
            rd_cnt_n = '0;
            pend_n   = pending && trig_c;
          end else begin
            state_n = S_IDLE;
          end
        end else if (trig_c) begin
          if (pending) begin
            ovr_n = 1'b1;
          end else begin
            pend_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    vld_n  = rd_en_c;
    full_n = (fill_n == CW'(WINDOW));

    if (clr) begin
      state_n   = S_IDLE;
      wr_ptr_n  = '0;
      old_ptr_n = '0;
      rd_ptr_n  = '0;
      rd_cnt_n  = '0;
      fill_n    = '0;
      phase_n   = '0;
      pend_n    = 1'b0;
      ovr_n     = 1'b0;
      vld_n     = 1'b0;
      full_n    = 1'b0;
    end
  end

  assign we_c = accept_c && !clr;

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      old_ptr  <= '0;
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      fill_cnt <= '0;
      phase    <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      smpl_vld <= 1'b0;
      full     <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      old_ptr  <= old_ptr_n;
      rd_ptr   <= rd_ptr_n;
      rd_cnt   <= rd_cnt_n;
      fill_cnt <= fill_n;
      phase    <= phase_n;
      pending  <= pend_n;
      overrun  <= ovr_n;
      smpl_vld <= vld_n;
      full     <= full_n;
    end
  end

  assign sequencing = (state == S_BURST);

  // Sample RAM write port; contents survive reset and clr
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[wr_ptr] <= new_smpl;
    end
  end

  // Registered read port, one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_out <= '0;
    end else if (clr) begin
      smpl_out <= '0;
    end else if (rd_en_c) begin
      smpl_out <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_circ_smpl_queue.sv
// Directed bench for circ_smpl_queue: DEPTH=8, WINDOW=5, with one DECIM=2 and one DECIM=1 instance.
module tb_circ_smpl_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clr0 = 1'b0, wrt0 = 1'b0;
  logic [15:0] new0 = '0;
  logic [15:0] out0;
  logic        vld0, seq0, full0, ovr0;
  logic [3:0]  fill0;

  logic        clr1 = 1'b0, wrt1 = 1'b0;
  logic [15:0] new1 = '0;
  logic [15:0] out1;
  logic        vld1, seq1, full1, ovr1;
  logic [3:0]  fill1;

  int n_chk = 0;
  int n_fail = 0;
  int hist[$];

  always #5 clk = ~clk;

  circ_smpl_queue #(.WIDTH(16), .DEPTH(8), .WINDOW(5), .DECIM(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .new_smpl(new0), .wrt_smpl(wrt0),
    .smpl_out(out0), .smpl_vld(vld0), .sequencing(seq0), .full(full0),
    .overrun(ovr0), .fill_cnt(fill0)
  );

  circ_smpl_queue #(.WIDTH(16), .DEPTH(8), .WINDOW(5), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .new_smpl(new1), .wrt_smpl(wrt1),
    .smpl_out(out1), .smpl_vld(vld1), .sequencing(seq1), .full(full1),
    .overrun(ovr1), .fill_cnt(fill1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe on dut; returns at the negedge after the strobe cycle
  task automatic strobe0(input int v);
    @(negedge clk);
    new0 = 16'(v);
    wrt0 = 1'b1;
    @(negedge clk);
    wrt0 = 1'b0;
  endtask

  task automatic strobe1(input int v);
    @(negedge clk);
    new1 = 16'(v);
    wrt1 = 1'b1;
    @(negedge clk);
    wrt1 = 1'b0;
  endtask

  // Called one cycle after the triggering strobe
  task automatic check_burst(input int e[5]);
    chk("seq_rise", int'(seq0), 1);
    chk("vld_latency", int'(vld0), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("burst_vld", int'(vld0), 1);
      chk("burst_data", int'(out0), e[i]);
    end
    @(negedge clk);
    chk("burst_end_vld", int'(vld0), 0);
    chk("burst_end_seq", int'(seq0), 0);
  endtask

  task automatic burst_hist();
    int e[5];
    for (int i = 0; i < 5; i++) e[i] = hist[hist.size() - 5 + i];
    check_burst(e);
  endtask

  initial begin
    int mph;
    int seq_cnt, rise_cnt, prev_vld, vcnt;
    int q1[$];
    int exp1[10];
    int e5[5];

    repeat (3) @(negedge clk);
    chk("rst_seq", int'(seq0), 0);
    chk("rst_vld", int'(vld0), 0);
    chk("rst_full", int'(full0), 0);
    chk("rst_ovr", int'(ovr0), 0);
    chk("rst_fill", int'(fill0), 0);
    chk("rst_out", int'(out0), 0);
    rst_n = 1'b1;

    // 1: first fill, burst of accepted even values
    for (int v = 1; v <= 10; v++) begin
      strobe0(v);
      if (v < 10) begin
        chk("fill_ramp", int'(fill0), v / 2);
        chk("no_early_seq", int'(seq0), 0);
      end
    end
    hist = '{2, 4, 6, 8, 10};
    chk("full_set", int'(full0), 1);
    chk("fill_5", int'(fill0), 5);
    burst_hist();

    // 2: one more accepted sample drops the oldest
    strobe0(11);
    repeat (19) @(negedge clk);
    strobe0(12);
    hist.push_back(12);
    chk("fill_hold", int'(fill0), 5);
    burst_hist();

    // 3: long run with pointer wrap
    mph = 0;
    for (int v = 1; v <= 40; v++) begin
      strobe0(v);
      if (mph == 1) begin
        mph = 0;
        hist.push_back(v);
        burst_hist();
      end else begin
        mph = 1;
        chk("no_trig", int'(seq0), 0);
      end
      repeat (12) @(negedge clk);
    end
    chk("fill_wrap", int'(fill0), 5);

    // 4: DECIM=1, back-to-back bursts and overrun
    for (int v = 1; v <= 5; v++) strobe1(v);
    repeat (10) @(negedge clk);
    chk("d1_fill", int'(fill1), 5);
    chk("d1_ovr0", int'(ovr1), 0);
    seq_cnt = 0;
    rise_cnt = 0;
    prev_vld = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (seq1) seq_cnt++;
      if (vld1 && prev_vld == 0) rise_cnt++;
      if (vld1) q1.push_back(int'(out1));
      prev_vld = int'(vld1);
      if (k == 0 || k == 2 || k == 4) begin
        wrt1 = 1'b1;
        new1 = 16'(6 + k / 2);
      end else begin
        wrt1 = 1'b0;
      end
    end
    chk("d1_seq_cycles", seq_cnt, 12);
    chk("d1_bursts", rise_cnt, 2);
    chk("d1_ovr", int'(ovr1), 1);
    chk("d1_nvals", q1.size(), 10);
    exp1 = '{2, 3, 4, 5, 6, 4, 5, 6, 7, 8};
    for (int i = 0; i < 10; i++) begin
      if (i < q1.size()) chk("d1_data", q1[i], exp1[i]);
      else chk("d1_data_missing", 0, exp1[i]);
    end

    // 5: reset in the third valid cycle of a burst
    strobe0(201);
    strobe0(202);
    repeat (3) @(negedge clk);
    chk("pre_rst_vld", int'(vld0), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(vld0), 0);
    chk("arst_seq", int'(seq0), 0);
    chk("arst_fill", int'(fill0), 0);
    chk("arst_full", int'(full0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 101; v <= 108; v++) strobe0(v);
    chk("refill_no_seq", int'(seq0), 0);
    chk("refill_4", int'(fill0), 4);
    strobe0(109);
    strobe0(110);
    chk("refill_full", int'(full0), 1);
    e5 = '{102, 104, 106, 108, 110};
    check_burst(e5);

    // 6: set overrun, then clr together with an accepted strobe
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wrt0 = 1'b1;
      new0 = 16'(300 + k);
    end
    @(negedge clk);
    wrt0 = 1'b0;
    chk("ovr_set", int'(ovr0), 1);
    strobe0(1);
    @(negedge clk);
    clr0 = 1'b1;
    wrt0 = 1'b1;
    new0 = 16'(999);
    @(negedge clk);
    clr0 = 1'b0;
    wrt0 = 1'b0;
    chk("clr_fill", int'(fill0), 0);
    chk("clr_ovr", int'(ovr0), 0);
    chk("clr_full", int'(full0), 0);
    chk("clr_seq", int'(seq0), 0);
    chk("clr_vld", int'(vld0), 0);
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (vld0) vcnt++;
    end
    chk("clr_no_burst", vcnt, 0);
    strobe0(2);
    chk("clr_phase", int'(fill0), 0);
    strobe0(3);
    chk("post_clr_accept", int'(fill0), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/circ_smpl_queue.md
Name: circ_smpl_queue

Overview:
Parametrised circular sample queue for the audio band-split path. It decimates the incoming sample stream by DECIM and stores accepted samples in an inferred dual-port RAM. Once WINDOW samples are held, every further accepted sample drops the oldest one and triggers a read-out burst of the whole window, oldest to newest, one sample per clk. Successor to the fixed 1024x16 low-frequency queue: single clock domain, configurable width, depth, window and decimation, plus valid, full and overrun status.

Parameters:
WIDTH, 16, sample width in bits
DEPTH, 1024, RAM depth; power of 2
WINDOW, 1021, samples per read-out burst; must satisfy 2 <= WINDOW <= DEPTH-1
DECIM, 2, decimation ratio; 1 accepts every strobe

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; same effect as reset, takes one cycle
new_smpl  in  WIDTH  incoming sample
wrt_smpl  in  1  one-clk strobe in the clk domain; new_smpl is valid while it is high
smpl_out  out  WIDTH  burst read data
smpl_vld  out  1  smpl_out is valid this cycle
sequencing  out  1  burst in progress
full  out  1  fill_cnt == WINDOW
overrun  out  1  sticky flag: a burst request was lost; cleared only by rst_n or clr
fill_cnt  out  $clog2(DEPTH+1)  number of samples held

Behaviour:
- Reset (rst_n low, asynchronous) and clr (synchronous) both zero all of the following: pointers, decimation phase, fill_cnt, pending flag, sequencing, smpl_vld, full, overrun. smpl_out resets to 0. RAM contents are not cleared.
- Decimation:
  - phase counter 0..DECIM-1 advances on each wrt_smpl.
  - A strobe is accepted when phase == DECIM-1; phase then wraps to 0.
  - With DECIM=2, strobes 2, 4, 6, ... are accepted.
- Accepted write at cycle T: RAM[wr_ptr] <= new_smpl at the edge ending T; wr_ptr increments modulo DEPTH.
  - If fill_cnt < WINDOW: fill_cnt increments.
  - Otherwise old_ptr increments modulo DEPTH (oldest sample dropped) and fill_cnt stays at WINDOW.
- Burst trigger: any accepted write that leaves fill_cnt == WINDOW, including the write that first fills the queue.
- Burst start when idle:
  - sequencing rises at T+1; start address is snapshotted as the post-update old_ptr.
  - Read addresses start, start+1, ..., start+WINDOW-1 (mod DEPTH) are issued on cycles T+1..T+WINDOW.
  - RAM read latency is 1: smpl_vld is high on T+2..T+WINDOW+1.
  - sequencing stays high through T+WINDOW+1, then falls.
- Overlap: write address start+WINDOW lies outside the snapshotted window (DEPTH > WINDOW), so writes during a burst never corrupt it.
- Trigger while sequencing: set pending. The next burst starts on the cycle after the current last valid, with no gap in sequencing, using the then-current old_ptr.
- Trigger while pending is already set: the request is dropped and overrun is set.
- Simultaneous events:
  - Accepted write in the same cycle as the last burst read: the write completes, and the new burst starts the next cycle.
  - clr together with wrt_smpl: clr wins and the sample is discarded.
- Reset or clr mid-burst: sequencing and smpl_vld drop immediately (asynchronously for reset, next edge for clr), and the burst is abandoned.
- All pointer arithmetic is modulo DEPTH, with natural wrap at pointer width $clog2(DEPTH).

Test Plan:
Bench parameters: WIDTH=16, DEPTH=8, WINDOW=5, DECIM=2 unless stated.
1. Reset, then 10 strobes carrying 1..10 -> accepted values 2,4,6,8,10; 5th accept sets full and fill_cnt=5; one burst outputs 2,4,6,8,10 with smpl_vld high for exactly 5 cycles, first valid 2 clks after the strobe.
2. Continue with strobes 11,12 spaced 20 clks apart -> 12 accepted; burst outputs 4,6,8,10,12; fill_cnt stays 5.
3. Drive 40 strobes (values 1..40) spaced 20 clks apart -> pointer wraps past 7 twice; every burst holds the 5 most recent accepted values in order.
4. DECIM=1; after fill, two accepted strobes 2 clks apart during a burst -> second burst follows back-to-back (sequencing never drops); a third strobe while pending -> overrun=1, and only 2 bursts are seen.
5. Assert rst_n low in the 3rd valid cycle of a burst -> smpl_vld, sequencing and fill_cnt are 0 immediately; 5 fresh accepts are needed before the next burst.
6. clr asserted in the same cycle as an accepted wrt_smpl -> fill_cnt=0 and no burst; overrun is cleared.
